rx_read_scheduler: RTL

Credit-based scheduler between the TCP stack's RX notification stream and its read-package request port. It admits only notifications whose payload fits the downstream receive FIFO. It issues a read request only when enough beat credits are free, and it reclaims credits as the consumer drains payload beats. The block replaces the stateless notification filter in the RX path, so the payload FIFO can never be overrun.

---
 rtl/rx_sched_pkg.sv | 29 ++
 rtl/rx_credit_counter.sv | 63 ++++++
 rtl/rx_read_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rx_sched_pkg.sv
// Shared definitions for the RX read scheduler:
// notification field layout, beat geometry, FSM states.
package rx_sched_pkg;

  localparam int NTF_W      = 88;
  localparam int SESS_LSB   = 0;
  localparam int SESS_W     = 16;
  localparam int LEN_LSB    = 16;
  localparam int LEN_W      = 16;
  localparam int BEAT_BYTES = 64;
  localparam int BEAT_SHIFT = 6;
  localparam int BEATS_W    = LEN_W - BEAT_SHIFT + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_ISSUE
  } state_t;

  function automatic logic [BEATS_W-1:0] len_to_beats(
    input logic [LEN_W-1:0] len
  );
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(BEAT_BYTES - 1);
    return sum[LEN_W:BEAT_SHIFT];
  endfunction

endpackage

// File: rtl/rx_credit_counter.sv
// Beat credit and outstanding-read bookkeeping with
// same-cycle netting, saturation and a sticky error flag.
module rx_credit_counter
  import rx_sched_pkg::*;
#(
  parameter int CREDIT_BEATS    = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CW = $clog2(CREDIT_BEATS + 1),
  parameter int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          beat_done_i,
  input  logic          beat_last_i,
  input  logic          issue_i,
  input  logic [CW-1:0] beats_i,
  output logic [CW-1:0] credits_o,
  output logic [CW-1:0] credits_nxt_o,
  output logic [OW-1:0] outst_o,
  output logic [OW-1:0] outst_nxt_o,
  output logic          err_o
);

  logic [CW-1:0] cred_q, cred_d;
  logic [OW-1:0] out_q, out_d;
  logic          err_q, err_d;
  logic          ovf, und, dec;

  always_comb begin
    ovf = beat_done_i && !issue_i
        && (cred_q == CW'(CREDIT_BEATS));
    dec = beat_done_i && beat_last_i;
    und = dec && !issue_i && (out_q == '0);
    cred_d = cred_q
           + CW'(beat_done_i && !ovf)
           - (issue_i ? beats_i : '0);
    out_d = out_q;
    if (issue_i && !dec)
      out_d = out_q + 1'b1;
    else if (dec && !issue_i && !und)
      out_d = out_q - 1'b1;
    err_d = err_q | ovf | und;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cred_q <= CW'(CREDIT_BEATS);
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cred_q <= cred_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  assign credits_o     = cred_q;
  assign credits_nxt_o = cred_d;
  assign outst_o       = out_q;
  assign outst_nxt_o   = out_d;
  assign err_o         = err_q;

endmodule

// File: rtl/rx_read_scheduler.sv
// Credit-gated RX notification to read-request scheduler.
// RX_SCHED_STATS_EN enables the drop/issue statistics counters.
module rx_read_scheduler
  import rx_sched_pkg::*;
#(
  parameter int CREDIT_BEATS    = 32,
  parameter int MAX_LEN         = 1536,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [87:0] s_axis_notifications_TDATA,
  input  logic        s_axis_notifications_TVALID,
  output logic        s_axis_notifications_TREADY,
  output logic [31:0] m_axis_read_package_TDATA,
  output logic        m_axis_read_package_TVALID,
  input  logic        m_axis_read_package_TREADY,
  input  logic        beat_done,
  input  logic        beat_last,
  output logic [$clog2(CREDIT_BEATS+1)-1:0] credits,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic        credit_err,
  output logic [31:0] drop_count,
  output logic [31:0] issue_count
);

  localparam int CW = $clog2(CREDIT_BEATS + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  state_t            state_q, state_d;
  logic [SESS_W-1:0] sess_q;
  logic [LEN_W-1:0]  len_q;
  logic [CW-1:0]     beats, cred_nxt;
  logic [OW-1:0]     out_nxt;
  logic              len_ok, can_go;
  logic              ntf_hs, issue_hs, drop_inc;
  logic              unused_ntf;

  assign unused_ntf = ^s_axis_notifications_TDATA[87:32];
  assign beats = CW'(len_to_beats(len_q));

  assign len_ok = (len_q != '0)
               && (len_q[BEAT_SHIFT-1:0] == '0)
               && (32'(len_q) <= MAX_LEN);

  // Look at next-cycle counts so a freeing beat releases at once
  assign can_go = (cred_nxt >= beats)
               && (out_nxt < OW'(MAX_OUTSTANDING));

  rx_credit_counter #(
    .CREDIT_BEATS    (CREDIT_BEATS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_cc (
    .clk_i         (clk),
    .rst_i         (rst),
    .beat_done_i   (beat_done),
    .beat_last_i   (beat_last),
    .issue_i       (issue_hs),
    .beats_i       (beats),
    .credits_o     (credits),
    .credits_nxt_o (cred_nxt),
    .outst_o       (outstanding),
    .outst_nxt_o   (out_nxt),
    .err_o         (credit_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (s_axis_notifications_TVALID)
          state_d = S_CHECK;
      S_CHECK:
        if (!len_ok)     state_d = S_IDLE;
        else if (can_go) state_d = S_ISSUE;
        else             state_d = S_WAIT;
      S_WAIT:
        if (can_go) state_d = S_ISSUE;
      S_ISSUE:
        if (m_axis_read_package_TREADY)
          state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_axis_notifications_TREADY = (state_q == S_IDLE);
    m_axis_read_package_TVALID  = (state_q == S_ISSUE);
    m_axis_read_package_TDATA   = '0;
    if (state_q == S_ISSUE)
      m_axis_read_package_TDATA = {len_q, sess_q};
    drop_inc = (state_q == S_CHECK) && !len_ok;
  end

  assign ntf_hs = s_axis_notifications_TVALID
               && s_axis_notifications_TREADY;
  assign issue_hs = m_axis_read_package_TVALID
                 && m_axis_read_package_TREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      sess_q <= '0;
      len_q  <= '0;
    end else if (ntf_hs) begin
      sess_q <= s_axis_notifications_TDATA[SESS_LSB +: SESS_W];
      len_q  <= s_axis_notifications_TDATA[LEN_LSB +: LEN_W];
    end
  end

`ifdef RX_SCHED_STATS_EN
  logic [31:0] drop_q, issue_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q  <= '0;
      issue_q <= '0;
    end else begin
      if (drop_inc) drop_q  <= drop_q + 1'b1;
      if (issue_hs) issue_q <= issue_q + 1'b1;
    end
  end

  assign drop_count  = drop_q;
  assign issue_count = issue_q;
`else
  logic unused_stats;
  assign unused_stats = drop_inc;
  assign drop_count   = '0;
  assign issue_count  = '0;
`endif

endmodule
